// File: rtl/host_txq.sv
// host_txq: multi-channel host transmit queue.
// Priority-arbitrated pushes into a ring buffer, registered read port,
// drop/collision accounting and a threshold-gated service request.
module host_txq #(
  parameter int DW     = 16,
  parameter int AW     = 10,
  parameter int NCH    = 4,
  parameter int SRQ_TH = 1
) (
  input  logic              hb_clk,
  input  logic              hb_rst_n,
  input  logic [NCH-1:0]    ch_wr,
  input  logic [NCH*DW-1:0] ch_din,
  input  logic              flush,
  input  logic              arm,
  output logic              srq,
  input  logic              srq_ack,
  input  logic              rd_en,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic [AW:0]       level,
  output logic              empty,
  output logic              full,
  output logic              ovfl,
  input  logic              ovfl_clr,
  output logic              coll,
  output logic [15:0]       drop_cnt
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] TH_L    = (AW+1)'(SRQ_TH);

  typedef enum logic {IDLE, ARMED} srq_state_e;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic          ovfl_q, ovfl_d, coll_q, coll_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  srq_state_e    state_q, state_d;
  logic          srq_q, srq_d;

  logic          any_wr, push, pop, reject, full_w, empty_w;
  logic [16:0]   n_wr, losers, drop_inc, drop_sum;
  logic [DW-1:0] win_data;

  assign full_w  = (level_q == DEPTH_L);
  assign empty_w = (level_q == '0);

  // Arbitration: lowest-indexed requester wins; count all requesters.
  always_comb begin
    any_wr   = 1'b0;
    n_wr     = '0;
    win_data = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (ch_wr[k]) begin
        if (!any_wr) win_data = ch_din[k*DW +: DW];
        any_wr = 1'b1;
        n_wr   = n_wr + 17'd1;
      end
    end
  end

  // Next-state for pointers, occupancy, accounting and SRQ FSM.
  always_comb begin
    // A pop while full frees the slot the push needs, so both proceed.
    push     = any_wr && !flush && (!full_w || rd_en);
    pop      = rd_en && !empty_w && !flush;
    reject   = any_wr && !flush && full_w && !rd_en;
    losers   = (any_wr && !flush) ? (n_wr - 17'd1) : '0;
    drop_inc = losers + 17'(reject);
    drop_sum = {1'b0, drop_cnt_q} + drop_inc;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) level_d = level_q + 1'b1;
      if (pop && !push) level_d = level_q - 1'b1;
    end

    if (ovfl_clr) begin
      ovfl_d     = 1'b0;
      coll_d     = 1'b0;
      drop_cnt_d = '0;
    end else begin
      ovfl_d     = ovfl_q | reject;
      coll_d     = coll_q | (losers != '0);
      drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    state_d = state_q;
    if (flush || srq_ack) state_d = IDLE;
    else if (arm)         state_d = ARMED;

    srq_d = (state_q == ARMED) && (level_q >= TH_L);
  end

  // Control/status registers and the registered read port.
  always_ff @(posedge hb_clk or negedge hb_rst_n) begin
    if (!hb_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovfl_q     <= 1'b0;
      coll_q     <= 1'b0;
      drop_cnt_q <= '0;
      state_q    <= IDLE;
      srq_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      rd_valid_q <= pop;
      if (pop) rd_data_q <= mem_q[rd_ptr_q];
      ovfl_q     <= ovfl_d;
      coll_q     <= coll_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
      srq_q      <= srq_d;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge hb_clk) begin
    if (push) mem_q[wr_ptr_q] <= win_data;
  end

  assign srq      = srq_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign level    = level_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign ovfl     = ovfl_q;
  assign coll     = coll_q;
  assign drop_cnt = drop_cnt_q;

endmodule
